pwm_capture: RTL
================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The block SHALL use one clock `clk`; reset `rst` SHALL be synchronous and active-low (asserted when 0, sampled on the `clk` rising edge).
REQ-002 Parameter MIN_CLKS, default 100000, SHALL be the pulse width (clk cycles) that maps to code 0 (1.0 ms at 100 MHz).
REQ-003 Parameter TICK_CLKS, default 391, SHALL be the clk cycles per code step above MIN_CLKS.
REQ-004 Parameter MAX_HIGH_CLKS, default 250000, SHALL be the pulse width above which a pulse is rejected.
REQ-005 Parameter TIMEOUT_CLKS, default 2500000, SHALL be the gap between rising edges after which a channel is declared lost.
REQ-006 Parameter NEUTRAL, default 8'd128, SHALL be the code loaded on reset and on timeout.
REQ-007 Port clk, input, 1: system clock.
REQ-008 Port rst, input, 1: synchronous active-low reset.
REQ-009 Port dir_in, input, 1: asynchronous direction PWM from the RC receiver.
REQ-010 Port spd_in, input, 1: asynchronous speed PWM from the RC receiver.
REQ-011 Port data_out, output, 16: {direction code[15:8], speed code[7:0]}, the same packing the PWM generator consumes.
REQ-012 Port valid, output, 1: one-cycle strobe when any data_out byte changes source value (capture or timeout).
REQ-013 Port dir_ok / spd_ok, outputs, 1 each: the channel has produced a good pulse since its last timeout/reset.

Function
REQ-014 Each input SHALL pass through a 2-flop synchronizer plus one edge-detect register; all edge references below are on the synchronized signal.
REQ-015 The two channels SHALL be identical, independent instances of one FSM with states IDLE, OFFSET, MEASURE, REJECT.
REQ-016 IDLE: on a rising edge, clear the width counter and go to OFFSET; otherwise stay.
REQ-017 OFFSET: count cycles; on a falling edge before MIN_CLKS, capture code 0 and go to IDLE; on reaching MIN_CLKS, go to MEASURE with the code accumulator at 0.
REQ-018 MEASURE: increment the accumulator every TICK_CLKS cycles, saturating at 255; on a falling edge, capture the accumulator and go to IDLE.
REQ-019 In OFFSET or MEASURE, if total high time exceeds MAX_HIGH_CLKS, the FSM SHALL go to REJECT with no capture; REJECT SHALL return to IDLE on the falling edge.
REQ-020 Code SHALL equal 0 for width <= MIN_CLKS, else min(255, floor((width-MIN_CLKS)/TICK_CLKS)), with width in synchronized cycles.
REQ-021 A capture SHALL update its data_out byte, set its *_ok, and pulse valid exactly 3 clk cycles after the first clk edge that samples the raw falling input.
REQ-022 A per-channel 22-bit gap counter SHALL clear on every rising edge and saturate; on reaching TIMEOUT_CLKS it SHALL load NEUTRAL into the channel byte, clear *_ok, and pulse valid once (not repeatedly while lost).
REQ-023 Both channels updating in the same cycle SHALL produce a single valid pulse with both bytes updated.
REQ-024 A capture and a timeout coinciding on the same channel SHALL give priority to the capture.
REQ-025 Counter widths SHALL be sized from the parameters; the code accumulator SHALL be 8 bits with explicit saturation, never wrapping.

Reset
REQ-026 While rst=0: data_out = {NEUTRAL, NEUTRAL}, valid=0, dir_ok=0, spd_ok=0, both FSMs IDLE, and all counters and synchronizers cleared.
REQ-027 Reset asserted mid-pulse SHALL abort the capture; an input already high at reset release SHALL be ignored until it goes low and rises again.

Verification
REQ-028 Directed test: dir_in high 150000 cycles -> data_out[15:8]=127, valid one pulse, dir_ok=1, and data_out[7:0] unchanged.
REQ-029 Directed test: spd_in high 100000 cycles, then 50000 cycles -> code 0 both times, each with one valid pulse.
REQ-030 Directed test: spd_in high 200000 cycles -> code 255 (saturated); high 300000 cycles -> no valid, code holds 255.
REQ-031 Directed test: both inputs fall on the same cycle (150000 and 200000 high) -> one valid pulse, data_out=16'h7FFF.
REQ-032 Directed test: after a good capture, hold dir_in low for 2500000 cycles -> data_out[15:8]=128, dir_ok=0, exactly one valid pulse.
REQ-033 Directed test: assert rst=0 at cycle 50000 of a 150000-cycle pulse, then release -> outputs at reset values, no capture from that pulse, and the next full pulse is captured correctly.

Source files
------------

// File: rtl/pwm_capture.sv
// Two-channel RC PWM decoder: converts receiver pulse widths into 8-bit codes
// packed as {direction, speed}, with per-channel loss-of-signal detection.

module pwm_capture_chan #(
    parameter int MIN_CLKS      = 100000,
    parameter int TICK_CLKS     = 391,
    parameter int MAX_HIGH_CLKS = 250000,
    parameter int TIMEOUT_CLKS  = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_in,
    output logic       cap_o,
    output logic [7:0] code_o,
    output logic       lost_o,
    output logic [1:0] state_o
);
    localparam int WW = $clog2(MAX_HIGH_CLKS + 1);
    localparam int TW = $clog2(TICK_CLKS + 1);
    localparam int GW = $clog2(TIMEOUT_CLKS + 1);

    // width_q holds (high cycles so far - 2) while a high cycle is being processed
    localparam logic [WW-1:0] OFS_LAST  = WW'(MIN_CLKS - 2);
    localparam logic [WW-1:0] REJ_AT    = WW'(MAX_HIGH_CLKS - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CLKS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(TIMEOUT_CLKS - 1);
    localparam logic [GW-1:0] GAP_MAX   = GW'(TIMEOUT_CLKS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFSET  = 2'd1,
        MEASURE = 2'd2,
        REJECT  = 2'd3
    } state_t;

    state_t          state_q;
    logic            s1_q, s2_q, s3_q;
    logic            v1_q, v2_q, armed_q;
    logic [WW-1:0]   width_q;
    logic [TW-1:0]   tick_q;
    logic [7:0]      acc_q;
    logic [7:0]      code_q;
    logic            cap_q;
    logic [GW-1:0]   gap_q;
    logic            lost_q;
    logic            rise;
    logic            fall;

    // armed_q only sets once a real (post-reset) sample has been seen low, so a
    // pulse already in progress at reset release is never measured
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            s1_q <= pwm_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
            v1_q <= 1'b1;
            v2_q <= v1_q;
            if (v2_q && !s2_q) armed_q <= 1'b1;
        end
    end

    assign rise = armed_q & s2_q & ~s3_q;
    assign fall = s3_q & ~s2_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            width_q <= '0;
            tick_q  <= '0;
            acc_q   <= 8'd0;
            code_q  <= 8'd0;
            cap_q   <= 1'b0;
        end else begin
            cap_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        width_q <= '0;
                        state_q <= OFFSET;
                    end
                end
                OFFSET: begin
                    if (fall) begin
                        code_q  <= 8'd0;
                        cap_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (width_q == REJ_AT) begin
                        state_q <= REJECT;
                    end else begin
                        width_q <= width_q + WW'(1);
                        if (width_q == OFS_LAST) begin
                            acc_q   <= 8'd0;
                            tick_q  <= '0;
                            state_q <= MEASURE;
                        end
                    end
                end
                MEASURE: begin
                    if (fall) begin
                        code_q  <= acc_q;
                        cap_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (width_q == REJ_AT) begin
                        state_q <= REJECT;
                    end else begin
                        width_q <= width_q + WW'(1);
                        if (tick_q == TICK_LAST) begin
                            tick_q <= '0;
                            if (acc_q != 8'hFF) acc_q <= acc_q + 8'd1;
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                end
                REJECT: begin
                    if (fall) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // lost_q fires only on the step into saturation, so one strobe per loss
    always_ff @(posedge clk) begin
        if (!rst) begin
            gap_q  <= '0;
            lost_q <= 1'b0;
        end else begin
            lost_q <= !rise && (gap_q == GAP_LAST);
            if (rise) gap_q <= '0;
            else if (gap_q != GAP_MAX) gap_q <= gap_q + GW'(1);
        end
    end

    assign cap_o   = cap_q;
    assign code_o  = code_q;
    assign lost_o  = lost_q;
    assign state_o = state_q;
endmodule

module pwm_capture #(
    parameter int         MIN_CLKS      = 100000,
    parameter int         TICK_CLKS     = 391,
    parameter int         MAX_HIGH_CLKS = 250000,
    parameter int         TIMEOUT_CLKS  = 2500000,
    parameter logic [7:0] NEUTRAL       = 8'd128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dir_in,
    input  logic        spd_in,
    output logic [15:0] data_out,
    output logic        valid,
    output logic        dir_ok,
    output logic        spd_ok,
    output logic [1:0]  dir_state,
    output logic [1:0]  spd_state
);
    logic       dir_cap, dir_lost, spd_cap, spd_lost;
    logic [7:0] dir_code, spd_code;
    logic [15:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       dir_ok_q, dir_ok_d, spd_ok_q, spd_ok_d;

    pwm_capture_chan #(
        .MIN_CLKS(MIN_CLKS), .TICK_CLKS(TICK_CLKS),
        .MAX_HIGH_CLKS(MAX_HIGH_CLKS), .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_dir (
        .clk(clk), .rst(rst), .pwm_in(dir_in),
        .cap_o(dir_cap), .code_o(dir_code), .lost_o(dir_lost), .state_o(dir_state)
    );

    pwm_capture_chan #(
        .MIN_CLKS(MIN_CLKS), .TICK_CLKS(TICK_CLKS),
        .MAX_HIGH_CLKS(MAX_HIGH_CLKS), .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_spd (
        .clk(clk), .rst(rst), .pwm_in(spd_in),
        .cap_o(spd_cap), .code_o(spd_code), .lost_o(spd_lost), .state_o(spd_state)
    );

    // A capture wins over a coincident timeout on the same channel
    always_comb begin
        data_d   = data_q;
        dir_ok_d = dir_ok_q;
        spd_ok_d = spd_ok_q;
        valid_d  = dir_cap | dir_lost | spd_cap | spd_lost;
        if (dir_cap) begin
            data_d[15:8] = dir_code;
            dir_ok_d     = 1'b1;
        end else if (dir_lost) begin
            data_d[15:8] = NEUTRAL;
            dir_ok_d     = 1'b0;
        end
        if (spd_cap) begin
            data_d[7:0] = spd_code;
            spd_ok_d    = 1'b1;
        end else if (spd_lost) begin
            data_d[7:0] = NEUTRAL;
            spd_ok_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q   <= {NEUTRAL, NEUTRAL};
            valid_q  <= 1'b0;
            dir_ok_q <= 1'b0;
            spd_ok_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            dir_ok_q <= dir_ok_d;
            spd_ok_q <= spd_ok_d;
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign dir_ok   = dir_ok_q;
    assign spd_ok   = spd_ok_q;
endmodule
